// File: rtl/alu_issue_stage.sv
// ALU issue stage: checks incoming instructions and drops illegal ones.
// Legal instructions wait in a small in-order queue and then move into
// an output register that drives the ALU operand and opcode ports.
// An instruction that arrives while both the queue and the output register
// are empty skips the queue. It appears on out_* one cycle after acceptance.
module alu_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            in_instr,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [3:0]             out_op,
  output logic [3:0]             out_rs1,
  output logic [3:0]             out_rs2,
  output logic [3:0]             out_rs3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   illegal,
  output logic [7:0]             illegal_count,
  output logic [7:0]             issue_count,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   out_instr_q, out_instr_d;
  logic          out_valid_q, out_valid_d;
  logic          illegal_q, illegal_d;
  logic [7:0]    illegal_count_q, illegal_count_d;
  logic [7:0]    issue_count_q, issue_count_d;

  logic accept, op_illegal, acc_legal;
  logic out_xfer, loadable, q_empty;
  logic deq, bypass, enq;

  // Handshake decode. in_ready looks only at registered occupancy and rst,
  // never at out_ready, so a full queue stays closed for one cycle even
  // when it is being drained on the same edge.
  always_comb begin
    in_ready   = !rst && (level_q < DEPTH_L);
    accept     = in_valid && in_ready;
    op_illegal = (in_instr[15:12] >= 4'd1) && (in_instr[15:12] <= 4'd6);
    acc_legal  = accept && !op_illegal;
    out_xfer   = out_valid_q && out_ready;
    loadable   = !out_valid_q || out_xfer;
    q_empty    = (level_q == '0);
    deq        = loadable && !q_empty;
    bypass     = loadable && q_empty && acc_legal;
    enq        = acc_legal && !bypass;
  end

  // Next-state logic for the pointers, occupancy, output register and counters.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    out_instr_d     = out_instr_q;
    out_valid_d     = out_valid_q;
    illegal_d       = accept && op_illegal;
    illegal_count_d = illegal_count_q;
    issue_count_d   = issue_count_q;

    if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({enq, deq})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Fields keep their last value when nothing new is loaded.
    if (loadable) begin
      out_valid_d = deq || bypass;
      if (deq) begin
        out_instr_d = mem_q[rd_ptr_q];
      end else if (bypass) begin
        out_instr_d = in_instr;
      end
    end

    if (illegal_d && (illegal_count_q != 8'hFF)) illegal_count_d = illegal_count_q + 8'd1;
    if (out_xfer) issue_count_d = issue_count_q + 8'd1;
  end

  // Control and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      out_instr_q     <= '0;
      out_valid_q     <= 1'b0;
      illegal_q       <= 1'b0;
      illegal_count_q <= '0;
      issue_count_q   <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      out_instr_q     <= out_instr_d;
      out_valid_q     <= out_valid_d;
      illegal_q       <= illegal_d;
      illegal_count_q <= illegal_count_d;
      issue_count_q   <= issue_count_d;
    end
  end

  // Queue storage has no reset. Stale entries are never read, because
  // the pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= in_instr;
  end

  assign out_op        = out_instr_q[15:12];
  assign out_rs1       = out_instr_q[11:8];
  assign out_rs2       = out_instr_q[7:4];
  assign out_rs3       = out_instr_q[3:0];
  assign out_valid     = out_valid_q;
  assign illegal       = illegal_q;
  assign illegal_count = illegal_count_q;
  assign issue_count   = issue_count_q;
  assign level         = level_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage. The reference model tracks, as one ordered
// list, every legal instruction that has been accepted but not yet issued.
// The head of that list is what the ALU sees. The rest is the queue occupancy.
module tb_alu_issue_stage;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_op, out_rs1, out_rs2, out_rs3;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;
  logic [7:0]  illegal_count;
  logic [7:0]  issue_count;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  logic [15:0] pend[$];
  logic        m_ill;
  logic [7:0]  m_illc;
  logic [7:0]  m_issc;
  logic [15:0] m_last;
  logic [15:0] held;

  alu_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_valid(out_valid), .out_ready(out_ready), .illegal(illegal),
    .illegal_count(illegal_count), .issue_count(issue_count), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_level();
    return (pend.size() > 0) ? pend.size() - 1 : 0;
  endfunction

  // One clock cycle: drive inputs, check in_ready, advance the model at the edge, then check outputs.
  task automatic step(input logic r, input logic v, input logic [15:0] ins, input logic ordy);
    logic exp_rdy, acc;
    rst = r; in_valid = v; in_instr = ins; out_ready = ordy;
    #1;
    exp_rdy = !r && (m_level() < DEPTH);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      pend.delete();
      m_ill = 0; m_illc = 0; m_issc = 0; m_last = 0;
    end else begin
      m_ill = acc && (ins[15:12] >= 4'd1) && (ins[15:12] <= 4'd6);
      if (m_ill && m_illc != 8'd255) m_illc = m_illc + 8'd1;
      if (pend.size() > 0 && ordy) begin
        void'(pend.pop_front());
        m_issc = m_issc + 8'd1;
      end
      if (acc && !m_ill) pend.push_back(ins);
      if (pend.size() > 0) m_last = pend[0];
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, pend.size() > 0});
    check("level", {29'd0, level}, m_level());
    check("out_fields", {16'd0, out_op, out_rs1, out_rs2, out_rs3}, {16'd0, m_last});
    check("illegal", {31'd0, illegal}, {31'd0, m_ill});
    check("illegal_count", {24'd0, illegal_count}, {24'd0, m_illc});
    check("issue_count", {24'd0, issue_count}, {24'd0, m_issc});
  endtask

  function automatic logic [15:0] rand_legal();
    logic [15:0] x;
    x = 16'($urandom);
    if (x[15:12] >= 4'd1 && x[15:12] <= 4'd6) x[15:12] = 4'd7 + 4'($urandom_range(0, 8));
    return x;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    m_ill = 0; m_illc = 0; m_issc = 0; m_last = 0;

    // Reset state, with inputs offered during reset being ignored.
    step(1, 1, 16'hB123, 1);
    step(1, 1, 16'h7777, 1);
    check("reset_level", {29'd0, level}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);

    // A single instruction goes straight through and issues.
    step(0, 1, 16'hB123, 1);
    check("b123_op", {28'd0, out_op}, 32'hB);
    check("b123_rs", {20'd0, out_rs1, out_rs2, out_rs3}, 32'h123);
    check("b123_valid", {31'd0, out_valid}, 32'd1);
    step(0, 0, 16'h0, 1);
    check("b123_issue_count", {24'd0, issue_count}, 32'd1);
    check("b123_hold_after_fall", {16'd0, out_op, out_rs1, out_rs2, out_rs3}, 32'hB123);

    // Backpressure: five legal instructions, then the queue is full.
    for (int i = 0; i < 5; i++) step(0, 1, 16'hC000 + 16'(i * 16'h0111), 0);
    check("full_level", {29'd0, level}, 32'd4);
    held = {out_op, out_rs1, out_rs2, out_rs3};
    check("full_head", {16'd0, held}, 32'hC000);
    step(0, 1, 16'hD999, 0);
    step(0, 1, 16'hD999, 0);
    check("full_stable", {16'd0, out_op, out_rs1, out_rs2, out_rs3}, {16'd0, held});
    // Draining while full: in_ready stays low on the dequeue cycle.
    step(0, 1, 16'hEAAA, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 16'h0, 1);
    check("drain_issue_count", {24'd0, issue_count}, 32'd6);

    // An illegal instruction produces a single-cycle pulse.
    step(1, 0, 16'h0, 0);
    step(0, 1, 16'h3456, 0);
    check("illegal_pulse", {31'd0, illegal}, 32'd1);
    check("illegal_count_one", {24'd0, illegal_count}, 32'd1);
    step(0, 0, 16'h0, 0);
    check("illegal_pulse_end", {31'd0, illegal}, 32'd0);
    check("illegal_no_out", {31'd0, out_valid}, 32'd0);

    // illegal_count saturates at 255.
    for (int i = 0; i < 300; i++) step(0, 1, {4'(1 + (i % 6)), 12'($urandom)}, 0);
    check("illegal_sat", {24'd0, illegal_count}, 32'd255);

    // issue_count wraps past 255.
    step(1, 0, 16'h0, 0);
    for (int i = 0; i < 257; i++) step(0, 1, rand_legal(), 1);
    step(0, 0, 16'h0, 1);
    check("issue_wrap", {24'd0, issue_count}, 32'd1);

    // A reset in the middle of operation discards the queue and the output register.
    for (int i = 0; i < 4; i++) step(0, 1, rand_legal(), 0);
    check("pre_rst_level", {29'd0, level}, 32'd3);
    step(1, 1, rand_legal(), 1);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_counts", {16'd0, illegal_count, issue_count}, 32'd0);
    step(0, 0, 16'h0, 0);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ins;
      ins = ($urandom_range(0, 3) == 0) ? 16'($urandom) : rand_legal();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, ins, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
